// File: rtl/pwm_env_pkg.sv
// pwm_env_pkg
// Shared types and constants for the PWM envelope generator: the envelope
// FSM state encoding, the duty-cycle width and ceiling, and the width used
// for duty arithmetic (one bit wider than the duty so sums cannot wrap).
// No ports.
package pwm_env_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    DECAY
  } env_state_t;

  localparam int DUTY_W      = 7;
  localparam int DUTY_MAX    = 99;
  localparam int ENV_ARITH_W = 8;

endpackage

// File: rtl/pwm_envelope_gen_if.sv
// pwm_envelope_gen_if
// Groups the strike input and envelope outputs of pwm_envelope_gen.
// Signals:
//   hit_in     - level strike request (already synchronized)
//   duty_cycle - envelope level 0..99 towards the PWM serializer
//   hit_out    - high while an envelope is running
//   env_done   - one-cycle pulse when the envelope returns to idle
// Modports:
//   master - strike source / envelope consumer
//   slave  - the envelope generator itself
interface pwm_envelope_gen_if;
  import pwm_env_pkg::*;

  logic              hit_in;
  logic [DUTY_W-1:0] duty_cycle;
  logic              hit_out;
  logic              env_done;

  modport master (output hit_in, input duty_cycle, hit_out, env_done);
  modport slave  (input hit_in, output duty_cycle, hit_out, env_done);

endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen
// Envelope step prescaler: a counter running 0..TICK_DIV-1 that wraps, with
// a synchronous clear. tick is high for the one cycle the counter sits at
// TICK_DIV-1.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - synchronous counter clear (wins over wrap/increment)
//   tick  - one-cycle step strobe
module pwm_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_div_check
    $error("pwm_tick_gen: TICK_DIV must be >= 1");
  end

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == CNT_LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_LAST);

endmodule

// File: rtl/pwm_envelope_gen.sv
// pwm_envelope_gen
// Turns a strike (rising edge of hit_in) into a duty-cycle envelope for the
// PWM serializer: attack ramp up to PEAK, hold for SUSTAIN_TICKS steps, then
// decay ramp down to 0. One envelope step happens per TICK_DIV clocks. All
// outputs are registered.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   env   - pwm_envelope_gen_if.slave (hit_in in; duty_cycle, hit_out,
//           env_done out)
// Optional feature macro: PWM_ENV_RETRIGGER_EN
//   defined   - a strike during an active envelope restarts the attack from
//               the current duty level
//   undefined - strikes during an active envelope are ignored
module pwm_envelope_gen
  import pwm_env_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int PEAK          = 99,
  parameter int ATTACK_STEP   = 3,
  parameter int DECAY_STEP    = 1,
  parameter int SUSTAIN_TICKS = 50
) (
  input logic             clk,
  input logic             reset,
  pwm_envelope_gen_if.slave env
);

`ifdef PWM_ENV_RETRIGGER_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  if (PEAK < 1 || PEAK > DUTY_MAX) begin : g_peak_check
    $error("pwm_envelope_gen: PEAK must be within 1..99");
  end
  if (ATTACK_STEP < 1 || DECAY_STEP < 1) begin : g_step_check
    $error("pwm_envelope_gen: ATTACK_STEP and DECAY_STEP must be >= 1");
  end
  if (SUSTAIN_TICKS < 0) begin : g_sustain_check
    $error("pwm_envelope_gen: SUSTAIN_TICKS must be >= 0");
  end

  // Steps larger than the duty ceiling behave identically to a step of
  // DUTY_MAX (clamp on attack, floor at 0 on decay), so clamping them keeps
  // the arithmetic inside ENV_ARITH_W bits with no possibility of wrap.
  localparam logic [ENV_ARITH_W-1:0] PEAK_A     = ENV_ARITH_W'(PEAK);
  localparam logic [DUTY_W-1:0]      PEAK_D     = DUTY_W'(PEAK);
  localparam logic [ENV_ARITH_W-1:0] ATTACK_INC =
    ENV_ARITH_W'((ATTACK_STEP > DUTY_MAX) ? DUTY_MAX : ATTACK_STEP);
  localparam logic [DUTY_W-1:0]      DECAY_DEC  =
    DUTY_W'((DECAY_STEP > DUTY_MAX) ? DUTY_MAX : DECAY_STEP);

  localparam int SUS_W = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS) : 1;
  localparam logic [SUS_W-1:0] SUS_LAST =
    SUS_W'((SUSTAIN_TICKS > 0) ? (SUSTAIN_TICKS - 1) : 0);
  localparam bit NO_SUSTAIN = (SUSTAIN_TICKS == 0);

  env_state_t              state_q, state_d;
  logic [DUTY_W-1:0]       duty_q, duty_d;
  logic [SUS_W-1:0]        sus_q, sus_d;
  logic                    hit_out_q, hit_out_d;
  logic                    env_done_q, env_done_d;
  logic                    hit_q;
  logic                    trig;
  logic                    tick;
  logic                    tick_clr;
  logic [ENV_ARITH_W-1:0]  attack_sum;

  // hit_q resets high so a strike already held through reset release is not
  // mistaken for a fresh rising edge.
  assign trig = env.hit_in & ~hit_q;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      sus_q      <= '0;
      hit_out_q  <= 1'b0;
      env_done_q <= 1'b0;
      hit_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      sus_q      <= sus_d;
      hit_out_q  <= hit_out_d;
      env_done_q <= env_done_d;
      hit_q      <= env.hit_in;
    end
  end

  // An accepted strike always beats a coincident tick: the tick is dropped
  // and the prescaler restarts so the next step is a full TICK_DIV away.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    sus_d      = sus_q;
    hit_out_d  = hit_out_q;
    env_done_d = 1'b0;
    tick_clr   = 1'b0;
    attack_sum = ENV_ARITH_W'(duty_q) + ATTACK_INC;

    if (trig && (state_q == IDLE)) begin
      state_d   = ATTACK;
      duty_d    = '0;
      sus_d     = '0;
      hit_out_d = 1'b1;
      tick_clr  = 1'b1;
    end else if (trig && RETRIG_EN) begin
      // Retrigger keeps the current level so the output does not click.
      state_d  = ATTACK;
      sus_d    = '0;
      tick_clr = 1'b1;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
        end
        ATTACK: begin
          if (attack_sum >= PEAK_A) begin
            duty_d  = PEAK_D;
            sus_d   = '0;
            state_d = NO_SUSTAIN ? DECAY : SUSTAIN;
          end else begin
            duty_d = attack_sum[DUTY_W-1:0];
          end
        end
        SUSTAIN: begin
          // Compare before incrementing so exactly SUSTAIN_TICKS ticks are
          // spent here.
          if (sus_q == SUS_LAST) begin
            state_d = DECAY;
          end else begin
            sus_d = sus_q + 1'b1;
          end
        end
        DECAY: begin
          if (duty_q <= DECAY_DEC) begin
            duty_d     = '0;
            state_d    = IDLE;
            hit_out_d  = 1'b0;
            env_done_d = 1'b1;
          end else begin
            duty_d = duty_q - DECAY_DEC;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign env.duty_cycle = duty_q;
  assign env.hit_out    = hit_out_q;
  assign env.env_done   = env_done_q;

endmodule

// File: tb/tb_pwm_envelope_gen.sv
// tb_pwm_envelope_gen
// Drives two envelope generators from the same strike/reset stimulus: one
// with the short test configuration (TICK_DIV=4, PEAK=9, ATTACK_STEP=4,
// DECAY_STEP=3, SUSTAIN_TICKS=2) and one boundary configuration (PEAK=99,
// ATTACK_STEP=50, SUSTAIN_TICKS=0). Every cycle both are compared with an
// envelope model kept here. Honors PWM_ENV_RETRIGGER_EN.
module tb_pwm_envelope_gen;
  import pwm_env_pkg::*;

  localparam int TD   = 4;
  localparam int PK   = 9;
  localparam int AS   = 4;
  localparam int DS   = 3;
  localparam int ST   = 2;
  localparam int B_PK = 99;
  localparam int B_AS = 50;
  localparam int B_ST = 0;

`ifdef PWM_ENV_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam int PH_ATK = 0;
  localparam int PH_SUS = 1;
  localparam int PH_DEC = 2;

  logic clk = 1'b0;
  logic reset;
  logic hit;

  int test_count = 0;
  int fail_count = 0;

  pwm_envelope_gen_if bus_a ();
  pwm_envelope_gen_if bus_b ();

  assign bus_a.hit_in = hit;
  assign bus_b.hit_in = hit;

  pwm_envelope_gen #(
    .TICK_DIV      (TD),
    .PEAK          (PK),
    .ATTACK_STEP   (AS),
    .DECAY_STEP    (DS),
    .SUSTAIN_TICKS (ST)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .env   (bus_a.slave)
  );

  pwm_envelope_gen #(
    .TICK_DIV      (TD),
    .PEAK          (B_PK),
    .ATTACK_STEP   (B_AS),
    .DECAY_STEP    (DS),
    .SUSTAIN_TICKS (B_ST)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .env   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Envelope model: an active flag, a phase, the level, the number of
  // clocks into the current step and the number of sustain steps held.
  typedef struct {
    int td;
    int peak;
    int atk;
    int dec;
    int sus;
    bit active;
    int phase;
    int duty;
    int cnt;
    int held;
    bit prev;
    bit done;
  } model_t;

  model_t ma;
  model_t mb;

  function automatic model_t model_step(model_t m_in, bit h, bit r);
    model_t m;
    bit     trig;
    bit     step;
    m = m_in;
    if (r) begin
      m.active = 1'b0;
      m.phase  = PH_ATK;
      m.duty   = 0;
      m.cnt    = 0;
      m.held   = 0;
      m.prev   = 1'b1;
      m.done   = 1'b0;
      return m;
    end
    trig   = h && !m.prev;
    m.prev = h;
    m.done = 1'b0;
    step   = (m.cnt == m.td - 1);
    m.cnt  = (m.cnt + 1) % m.td;
    if (trig && (!m.active || RETRIG)) begin
      if (!m.active) m.duty = 0;
      m.active = 1'b1;
      m.phase  = PH_ATK;
      m.cnt    = 0;
      m.held   = 0;
    end else if (m.active && step) begin
      if (m.phase == PH_ATK) begin
        m.duty = (m.duty + m.atk > m.peak) ? m.peak : m.duty + m.atk;
        if (m.duty == m.peak) begin
          m.phase = (m.sus == 0) ? PH_DEC : PH_SUS;
          m.held  = 0;
        end
      end else if (m.phase == PH_SUS) begin
        m.held = m.held + 1;
        if (m.held >= m.sus) m.phase = PH_DEC;
      end else begin
        m.duty = (m.duty > m.dec) ? m.duty - m.dec : 0;
        if (m.duty == 0) begin
          m.active = 1'b0;
          m.done   = 1'b1;
        end
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    ma = model_step(ma, hit, reset);
    mb = model_step(mb, hit, reset);
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareModels();
    checkOutput("a.duty_cycle", int'(bus_a.duty_cycle), ma.duty);
    checkOutput("a.hit_out",    int'(bus_a.hit_out),    int'(ma.active));
    checkOutput("a.env_done",   int'(bus_a.env_done),   int'(ma.done));
    checkOutput("b.duty_cycle", int'(bus_b.duty_cycle), mb.duty);
    checkOutput("b.hit_out",    int'(bus_b.hit_out),    int'(mb.active));
    checkOutput("b.env_done",   int'(bus_b.env_done),   int'(mb.done));
  endtask

  task automatic applyStimulus(input bit h, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      hit   = h;
      reset = r;
      @(negedge clk);
      compareModels();
    end
  endtask

  // Idles the strike input until the short-configuration model reaches the
  // given level and phase (and step position when cnt_req >= 0).
  task automatic waitModelA(input int duty_req, input int phase_req, input int cnt_req,
                            input string tag);
    int budget;
    budget = 200;
    while (budget > 0 && !(ma.active && ma.duty == duty_req && ma.phase == phase_req &&
                           (cnt_req < 0 || ma.cnt == cnt_req))) begin
      applyStimulus(1'b0, 1'b0, 1);
      budget--;
    end
    if (budget == 0) checkOutput(tag, ma.duty, duty_req);
  endtask

  initial begin
    ma = '{td: TD, peak: PK,   atk: AS,   dec: DS, sus: ST,   default: 0};
    mb = '{td: TD, peak: B_PK, atk: B_AS, dec: DS, sus: B_ST, default: 0};
    hit   = 1'b1;
    reset = 1'b1;

    // Reset with the strike held high, then release while still held.
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("reset.duty_cycle", int'(bus_a.duty_cycle), 0);
    checkOutput("reset.hit_out",    int'(bus_a.hit_out),    0);
    checkOutput("reset.env_done",   int'(bus_a.env_done),   0);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("held_through_reset.hit_out", int'(bus_a.hit_out), 0);
    applyStimulus(1'b0, 1'b0, 3);

    // Single one-cycle strike; hit_out must rise right after the sampling edge.
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("strike.latency", int'(bus_a.hit_out), 1);
    applyStimulus(1'b0, 1'b0, 160);

    // Strike held for 100 cycles: only one envelope.
    applyStimulus(1'b1, 1'b0, 100);
    applyStimulus(1'b0, 1'b0, 160);

    // Reset in ATTACK at duty 8 with hit_in high through the reset.
    applyStimulus(1'b1, 1'b0, 1);
    waitModelA(8, PH_ATK, -1, "wait.attack8");
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("mid_reset.duty_cycle", int'(bus_a.duty_cycle), 0);
    checkOutput("mid_reset.env_done",   int'(bus_a.env_done),   0);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 160);

    // Strike during DECAY at duty 6.
    applyStimulus(1'b1, 1'b0, 1);
    waitModelA(6, PH_DEC, -1, "wait.decay6");
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 200);

    // Rising edge sampled on the same edge as an ATTACK tick.
    applyStimulus(1'b1, 1'b0, 1);
    waitModelA(4, PH_ATK, TD - 1, "wait.attack_tick");
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 200);

    // Random strikes of varying length with occasional resets.
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'b1, 1'b0, int'($urandom_range(1, 12)));
      applyStimulus(1'b0, 1'b0, int'($urandom_range(1, 45)));
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 3)));
      end
    end
    applyStimulus(1'b0, 1'b0, 200);
    checkOutput("final.hit_out_b", int'(bus_b.hit_out), 0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pwm_envelope_gen.md
Name: pwm_envelope_gen

Overview:
Upstream driver for the PWM serializer. It converts a strike input into a time-shaped duty-cycle envelope: attack ramp, sustain hold, then decay ramp. Outputs `duty_cycle` (0..99) and `hit_out`, which feed the serializer's `duty_cycle` and `hit` inputs directly. All outputs are registered and change on posedge `clk`.

Parameters:
- TICK_DIV, 100000: clk cycles per envelope step (1 ms at 100 MHz); must be >= 1.
- PEAK, 99: attack target duty; legal range 1..99; elaboration error outside this range.
- ATTACK_STEP, 3: duty increment per tick in ATTACK; must be >= 1.
- DECAY_STEP, 1: duty decrement per tick in DECAY; must be >= 1.
- SUSTAIN_TICKS, 50: ticks held at PEAK; 0 means no sustain.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- hit_in, input, 1: level strike request, already synchronized; its rising edge triggers.
- duty_cycle, output, 7: envelope level, 0..99, to the serializer.
- hit_out, output, 1: high while the envelope is active (state != IDLE), to the serializer `hit`.
- env_done, output, 1: one-cycle pulse on the cycle the state returns to IDLE.

Behaviour:
- Synchronous active-high reset, one clock, `clk`.
- Reset values: state=IDLE, duty_cycle=0, hit_out=0, env_done=0, tick counter=0, sustain counter=0, hit_q=1.
  - hit_q=1 means a `hit_in` already held through reset release does not trigger.
- Trigger: `trig = hit_in & ~hit_q`, with hit_q registered every cycle.
- Tick: tick counter runs 0..TICK_DIV-1 and wraps. `tick` is asserted when the counter equals TICK_DIV-1. The counter clears to 0 on any accepted trigger.
- FSM states: IDLE, ATTACK, SUSTAIN, DECAY.
- IDLE:
  - On trig: next state ATTACK, duty_cycle=0, hit_out=1.
  - Latency: hit_out is high 1 cycle after the edge where `hit_in` is first sampled high.
- ATTACK, on tick:
  - duty = min(duty + ATTACK_STEP, PEAK), computed 8 bits wide, so there is no wrap.
  - When the new duty equals PEAK: go to SUSTAIN, with the sustain counter at 0.
  - If SUSTAIN_TICKS==0, go directly to DECAY instead.
- SUSTAIN, on tick:
  - Sustain counter increments.
  - When it reaches SUSTAIN_TICKS-1: go to DECAY; duty stays at PEAK.
- DECAY, on tick:
  - duty = (duty <= DECAY_STEP) ? 0 : duty - DECAY_STEP.
  - When the new duty is 0: go to IDLE. hit_out falls and env_done pulses on that same cycle, when duty_cycle becomes 0.
- Between ticks, duty_cycle holds its value.
- duty_cycle never exceeds PEAK (<=99) in any state.
- Trigger and tick in the same cycle: trigger takes priority, the tick is discarded, and the counter clears.
- Reset mid-envelope: the next cycle shows IDLE and all reset values; no env_done pulse.

Optional Feature:
PWM_ENV_RETRIGGER_EN
- Defined: trig in ATTACK, SUSTAIN or DECAY moves the FSM to ATTACK.
  - duty_cycle keeps its current value (no drop to 0).
  - Tick and sustain counters clear; hit_out stays 1; no env_done pulse.
- Undefined: trig outside IDLE is ignored; the envelope completes unchanged.

Decomposition:
- Package pwm_env_pkg contains:
  - state enum (IDLE, ATTACK, SUSTAIN, DECAY);
  - DUTY_W=7;
  - DUTY_MAX=99;
  - ENV_ARITH_W=8.
- Sub-module pwm_tick_gen: parameterized TICK_DIV prescaler with a sync clear input and a one-cycle `tick` output.
- The FSM and duty arithmetic stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4, PEAK=9, ATTACK_STEP=4, DECAY_STEP=3, SUSTAIN_TICKS=2.
- Single strike: hit_in high for 1 cycle. Required response:
  - hit_out=1 on the next cycle;
  - duty_cycle sequence 0 -> 4 -> 8 -> 9 (clamped) -> SUSTAIN 2 ticks -> 6 -> 3 -> 0, with each step 4 clk apart;
  - env_done pulses once with hit_out=0, duty_cycle=0.
- Held input: hit_in held high for 100 cycles. Exactly one envelope runs; no second trigger until hit_in falls and rises again.
- Reset at duty_cycle=8 in ATTACK: next cycle duty_cycle=0, hit_out=0, env_done=0. hit_in held high through reset produces no trigger.
- Strike in DECAY at duty_cycle=6:
  - Without PWM_ENV_RETRIGGER_EN: ignored; the decay continues 3 -> 0.
  - With PWM_ENV_RETRIGGER_EN: state ATTACK, duty_cycle goes 6 -> 9 after 4 clk, then SUSTAIN.
- Rising edge coincident with tick in ATTACK (build with PWM_ENV_RETRIGGER_EN): the tick is discarded, duty_cycle unchanged, and the next step occurs exactly 4 clk later.
- Boundary check with SUSTAIN_TICKS=0, PEAK=99, ATTACK_STEP=50:
  - 0 -> 50 -> 99, then DECAY immediately;
  - duty_cycle never exceeds 99;
  - decay reaches exactly 0 and ends in IDLE.
